// File: rtl/line_buffer_taps.sv
// Multi-tap RAM line buffer: TAPS cascaded line delays of runtime length Len_cur plus the current sample.
// Optional macro LB_FILL_ZERO_EN: taps that are not yet primed output 0 instead of stale RAM data.
module line_buffer_taps #(
  parameter int DSIZE     = 16,
  parameter int MAX_DEPTH = 800,
  parameter int TAPS      = 2,
  parameter int ASIZE     = $clog2(MAX_DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      Reset,
  input  logic [DSIZE-1:0]          Din,
  input  logic                      Din_valid,
  input  logic [ASIZE-1:0]          Len,
  input  logic                      Len_ld,
  output logic [(TAPS+1)*DSIZE-1:0] Q,
  output logic                      Q_valid,
  output logic [TAPS-1:0]           Tap_primed,
  output logic [ASIZE-1:0]          Len_cur
);
  localparam int FSIZE = $clog2(TAPS * MAX_DEPTH + 1);
  localparam int AW    = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;

  logic [ASIZE-1:0] len_cur_r;
  logic [ASIZE-1:0] len_clamped;
  logic [ASIZE-1:0] ptr;
  logic [FSIZE-1:0] fill;
  logic [FSIZE-1:0] fill_max;
  logic [TAPS-1:0]  reach;
  logic [TAPS-1:0]  primed;
  logic             q_valid_r;
  logic             accept;
  logic             wr_pend;
  logic [ASIZE-1:0] wr_addr;
  logic [DSIZE-1:0] tap0_q;
  logic [DSIZE-1:0] tap_w [TAPS+1];

  // Handshake: a sample is accepted on a rising edge when Din_valid is high and Len_ld is low;
  // Len_ld wins over Din_valid, and Q_valid marks the cycle after each accepted sample.
  assign accept = Din_valid & ~Len_ld;

  always_comb begin
    if (Len < ASIZE'(2))                 len_clamped = ASIZE'(2);
    else if (Len > ASIZE'(MAX_DEPTH))    len_clamped = ASIZE'(MAX_DEPTH);
    else                                 len_clamped = Len;
  end

  // reach[k-1]: the sample being accepted now is far enough in to land real data on tap k.
  always_comb begin
    fill_max = FSIZE'(TAPS * int'(len_cur_r));
    reach    = '0;
    for (int k = 0; k < TAPS; k++)
      reach[k] = (fill >= FSIZE'((k + 1) * int'(len_cur_r)));
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      len_cur_r <= ASIZE'(MAX_DEPTH);
      ptr       <= '0;
      fill      <= '0;
      primed    <= '0;
      q_valid_r <= 1'b0;
      wr_pend   <= 1'b0;
      wr_addr   <= '0;
      tap0_q    <= '0;
    end else begin
      q_valid_r <= accept;
      wr_pend   <= accept;
      wr_addr   <= ptr;
      if (Len_ld) begin
        len_cur_r <= len_clamped;
        ptr       <= '0;
        fill      <= '0;
        primed    <= '0;
      end else if (Din_valid) begin
        ptr    <= (ptr == len_cur_r - ASIZE'(1)) ? '0 : ptr + ASIZE'(1);
        if (fill != fill_max) fill <= fill + FSIZE'(1);
        primed <= primed | reach;
        tap0_q <= Din;
      end
    end
  end

  assign tap_w[0] = tap0_q;

  // Each tap reads at the pointer on accept and writes its input one cycle later at that same
  // address; Len_cur >= 2 guarantees the deferred write lands before the address is read again.
  for (genvar k = 1; k <= TAPS; k++) begin : g_tap
    logic [DSIZE-1:0] mem [MAX_DEPTH];
    logic [DSIZE-1:0] rd_q;

    always_ff @(posedge clk) begin
      if (wr_pend) mem[wr_addr[AW-1:0]] <= tap_w[k-1];
    end

    always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
        rd_q <= '0;
      end else if (accept) begin
`ifdef LB_FILL_ZERO_EN
        rd_q <= reach[k-1] ? mem[ptr[AW-1:0]] : '0;
`else
        rd_q <= mem[ptr[AW-1:0]];
`endif
      end
    end

    assign tap_w[k] = rd_q;
  end

  for (genvar k = 0; k <= TAPS; k++) begin : g_q
    assign Q[k*DSIZE +: DSIZE] = tap_w[k];
  end

  assign Q_valid    = q_valid_r;
  assign Tap_primed = primed;
  assign Len_cur    = len_cur_r;
endmodule

// File: tb/tb_line_buffer_taps.sv
// Bench for line_buffer_taps: queue-based model of accepted samples plus directed literal checks.
module tb_line_buffer_taps;
  localparam int DSIZE = 8;
  localparam int MAXD  = 16;
  localparam int TAPS  = 2;
  localparam int ASIZE = $clog2(MAXD + 1);

  logic                      clk = 1'b0;
  logic                      Reset;
  logic [DSIZE-1:0]          Din;
  logic                      Din_valid;
  logic [ASIZE-1:0]          Len;
  logic                      Len_ld;
  logic [(TAPS+1)*DSIZE-1:0] Q;
  logic                      Q_valid;
  logic [TAPS-1:0]           Tap_primed;
  logic [ASIZE-1:0]          Len_cur;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  line_buffer_taps #(.DSIZE(DSIZE), .MAX_DEPTH(MAXD), .TAPS(TAPS)) dut (
    .clk(clk), .Reset(Reset), .Din(Din), .Din_valid(Din_valid), .Len(Len), .Len_ld(Len_ld),
    .Q(Q), .Q_valid(Q_valid), .Tap_primed(Tap_primed), .Len_cur(Len_cur)
  );

  // clock / reset
  always #5 clk = ~clk;

  // model: every accepted sample since the last reset/load, in order
  logic [DSIZE-1:0] hist[$];
  int               m_len;
  bit               m_valid;
  logic [TAPS-1:0]  m_primed;
  logic [DSIZE-1:0] m_tap [TAPS+1];
  bit               m_known [TAPS+1];

  always @(posedge clk or posedge Reset) begin
    if (Reset) begin
      hist.delete();
      m_len    = MAXD;
      m_valid  = 1'b0;
      m_primed = '0;
      for (int k = 0; k <= TAPS; k++) begin
        m_tap[k]   = '0;
        m_known[k] = 1'b1;
      end
    end else if (Len_ld) begin
      m_len    = (int'(Len) < 2) ? 2 : (int'(Len) > MAXD) ? MAXD : int'(Len);
      hist.delete();
      m_valid  = 1'b0;
      m_primed = '0;
    end else if (Din_valid) begin
      int n;
      n = hist.size();
      hist.push_back(Din);
      m_valid    = 1'b1;
      m_tap[0]   = Din;
      m_known[0] = 1'b1;
      for (int k = 1; k <= TAPS; k++) begin
        if (n >= k * m_len) begin
          m_tap[k]   = hist[n - k * m_len];
          m_known[k] = 1'b1;
          m_primed[k-1] = 1'b1;
        end else begin
`ifdef LB_FILL_ZERO_EN
          m_tap[k]   = '0;
          m_known[k] = 1'b1;
`else
          m_known[k] = 1'b0;
`endif
        end
      end
    end else begin
      m_valid = 1'b0;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard compare, every cycle
  always @(negedge clk) begin
    if (chk_en && !Reset) begin
      chk("q_valid", int'(Q_valid), int'(m_valid));
      chk("tap_primed", int'(Tap_primed), int'(m_primed));
      chk("len_cur", int'(Len_cur), m_len);
      for (int k = 0; k <= TAPS; k++)
        if (m_known[k]) chk($sformatf("tap%0d", k), int'(Q[k*DSIZE +: DSIZE]), int'(m_tap[k]));
    end
  end

  // driver: apply one cycle of inputs, return just after the edge
  task automatic step(input int d, input bit v, input bit ld, input int len);
    Din       = DSIZE'(d);
    Din_valid = v;
    Len_ld    = ld;
    Len       = ASIZE'(len);
    @(posedge clk);
    #1;
  endtask

  function automatic int tap(input int k);
    return int'(Q[k*DSIZE +: DSIZE]);
  endfunction

  initial begin
    int idx;
    Reset = 1'b1; Din = '0; Din_valid = 1'b0; Len = '0; Len_ld = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_q", int'(Q), 0);
    chk("rst_valid", int'(Q_valid), 0);
    chk("rst_primed", int'(Tap_primed), 0);
    chk("rst_len", int'(Len_cur), 16);
    Reset  = 1'b0;
    chk_en = 1'b1;

    // continuous stream at Len=5
    step(0, 0, 1, 5);
    for (int i = 0; i <= 14; i++) begin
      step(i, 1, 0, 0);
      if (i == 4) chk("primed_s4", int'(Tap_primed), 0);
      if (i == 5) chk("primed_s5", int'(Tap_primed), 1);
      if (i == 9) chk("primed_s9", int'(Tap_primed), 1);
      if (i == 10) begin
        chk("s10_tap0", tap(0), 10);
        chk("s10_tap1", tap(1), 5);
        chk("s10_tap2", tap(2), 0);
        chk("s10_primed", int'(Tap_primed), 3);
      end
    end

    // same stream with a 1,0,0,1 valid pattern
    step(0, 0, 1, 5);
    idx = 0;
    for (int c = 0; idx <= 12; c++) begin
      bit v;
      v = (c % 4 == 0) || (c % 4 == 3);
      step(idx, v, 0, 0);
      if (v && idx == 10) begin
        chk("gap_tap0", tap(0), 10);
        chk("gap_tap1", tap(1), 5);
        chk("gap_tap2", tap(2), 0);
      end
      if (!v) chk("gap_hold_tap0", tap(0), idx - 1);
      if (v) idx++;
    end

    // length clamps, then long line
    step(0, 0, 1, 1);
    chk("clamp_lo", int'(Len_cur), 2);
    step(0, 0, 1, 20);
    chk("clamp_hi", int'(Len_cur), 16);
    step(0, 0, 1, 16);
    for (int i = 0; i <= 40; i++) step(i, 1, 0, 0);
    chk("l16_tap1", tap(1), 24);
    chk("l16_tap2", tap(2), 8);

    // load colliding with a valid sample
    step(0, 0, 1, 5);
    for (int i = 0; i < 12; i++) step(i, 1, 0, 0);
    step(99, 1, 1, 3);
    chk("ld_drop_valid", int'(Q_valid), 0);
    chk("ld_drop_primed", int'(Tap_primed), 0);
    chk("ld_drop_hold", tap(0), 11);
    for (int i = 0; i <= 3; i++) begin
      step(50 + i, 1, 0, 0);
      if (i == 2) chk("ld3_primed_i2", int'(Tap_primed), 0);
      if (i == 3) chk("ld3_primed_i3", int'(Tap_primed), 1);
    end

    // randomized traffic with occasional reloads
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 49) == 0)
        step($urandom_range(0, 255), 1'($urandom_range(0, 1)), 1, $urandom_range(0, 20));
      else
        step($urandom_range(0, 255), $urandom_range(0, 9) < 7, 0, 0);
    end

    // asynchronous reset mid-stream
    step(0, 0, 1, 4);
    for (int i = 0; i < 7; i++) step(100 + i, 1, 0, 0);
    Reset = 1'b1;
    #1;
    chk("amid_q", int'(Q), 0);
    chk("amid_valid", int'(Q_valid), 0);
    chk("amid_primed", int'(Tap_primed), 0);
    repeat (2) @(posedge clk);
    #1;
    Reset = 1'b0;
    step(8'h55, 1, 0, 0);
    chk("after_rst_tap0", tap(0), 8'h55);
    chk("after_rst_valid", int'(Q_valid), 1);

    // unprimed taps over stale RAM at Len=4
    step(0, 0, 1, 4);
    for (int i = 0; i < 10; i++) begin
      step(200 + i, 1, 0, 0);
`ifdef LB_FILL_ZERO_EN
      if (i == 1) begin
        chk("fz_tap1", tap(1), 0);
        chk("fz_tap2", tap(2), 0);
      end
`endif
      if (i == 9) chk("l4_tap2", tap(2), 201);
    end
    step(0, 0, 0, 0);
    chk_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/line_buffer_taps.md
Name: line_buffer_taps

Overview:
- Parametrised multi-tap line buffer built on RAM-based shift registers. This is the next generation of the single-tap fixed-length RAM shift register.
- Delays an input pixel stream by a runtime-selectable line length and exposes TAPS cascaded delayed lines plus the current sample. The outputs feed vertical-window filters in the object tracker video path.
- Adds the following, which the single-tap block does not have:
  - data-valid gating,
  - runtime length,
  - multiple taps,
  - per-tap primed status.

Parameters:
- DSIZE, 16, sample width in bits.
- MAX_DEPTH, 800, maximum line length; sets the RAM depth of each tap.
- TAPS, 2, number of delayed lines (RAM stages); TAPS >= 1.
- ASIZE, $clog2(MAX_DEPTH+1), width of the pointer and Len.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Din  in  DSIZE  input sample.
- Din_valid  in  1  sample accepted on a rising edge when high.
- Len  in  ASIZE  line length in samples; captured on Len_ld.
- Len_ld  in  1  one-cycle pulse: latch Len and restart fill tracking.
- Q  out  (TAPS+1)*DSIZE  Q[k*DSIZE +: DSIZE] = tap k; tap 0 = current sample.
- Q_valid  out  1  high one cycle after each accepted sample.
- Tap_primed  out  TAPS  bit k-1 high once tap k carries real data.
- Len_cur  out  ASIZE  active (clamped) line length.

Behaviour:
- Reset (asynchronous) values:
  - Q = 0, Q_valid = 0, Tap_primed = 0, Len_cur = MAX_DEPTH.
  - Write pointer = 0, fill counter = 0.
  - RAM contents are not cleared.
- Len clamp on load:
  - Len < 2 is loaded as 2.
  - Len > MAX_DEPTH is loaded as MAX_DEPTH.
  - Otherwise Len is loaded unchanged.
- Len_ld cycle:
  - Len_cur updates at the edge.
  - Pointer and fill counter go to 0; Tap_primed clears.
  - Q holds; Q_valid = 0 next cycle.
  - If Din_valid is high in the same cycle, Len_ld has priority and that sample is discarded.
- Accepted sample n (0-based count since the last Reset/Len_ld), Din_valid high at edge t; at edge t+1 (latency 1):
  - Q_valid = 1.
  - Tap 0 = sample n.
  - Tap k = sample n - k*Len_cur, for every k with n >= k*Len_cur.
  - Tap_primed[k-1] = 1 from the Q_valid of sample n = k*Len_cur onward; it is sticky until Reset/Len_ld.
  - Tap k before it is primed = stale RAM data (see Optional Feature).
- Din_valid low:
  - No pointer advance, no RAM write; Q holds; Q_valid = 0 next cycle.
  - Gaps of any length do not change delay relationships, which count samples, not cycles.
- Pointer:
  - Circular, 0..Len_cur-1, advances once per accepted sample.
  - Wraps to 0 after Len_cur-1 with no bubble.
- Fill counter: saturates at TAPS*Len_cur; it must not wrap.
- RAM:
  - One DSIZE x MAX_DEPTH memory per tap, synchronous read-before-write, inferable as Gowin BSRAM.
  - Tap k writes its own input (tap k-1 value) at the read address.
- Back-to-back sustained throughput: one sample per clock.
- Reset mid-stream: outputs go to reset values immediately. After release, tap data is stale until re-primed.

Optional Feature:
- Macro: LB_FILL_ZERO_EN.
- Defined: any tap k whose Tap_primed[k-1] = 0 outputs 0 on Q instead of RAM contents.
- Undefined: unprimed taps output whatever the RAM holds.
- Timing, Q_valid and Tap_primed are identical in both builds.

Test Plan (DSIZE=8, MAX_DEPTH=16, TAPS=2):
- Reset, Len_ld with Len=5, then Din = 0,1,2,... with Din_valid=1 every cycle -> for sample 10: tap0=10, tap1=5, tap2=0, Tap_primed=2'b11. Tap_primed[0] rises with sample 5, bit 1 rises with sample 10.
- Same stream with Din_valid toggling 1,0,0,1 pattern -> same tap values per sample index. Q_valid only follows accepted samples; Q holds during gaps.
- Len=1 and Len=20 -> Len_cur reads 2 and 16. With Len=16 at sample 40: tap1=24, tap2=8.
- Len_ld together with Din_valid after 12 samples at Len=5, new Len=3 -> that sample is dropped and Tap_primed clears. The next sample is index 0; Tap_primed[0] sets at index 3.
- Reset asserted mid-stream for 2 cycles -> Q=0, Q_valid=0, Tap_primed=0 asynchronously. The next accepted sample appears on tap0 after 1 cycle.
- With LB_FILL_ZERO_EN defined, garbage pre-loaded in RAM, Len=4 -> tap1/tap2 read 0 until primed. Without the macro, they show the RAM contents.
